// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port byte-addressed data memory.
// One access in flight: accept, registered memory strobe, one-cycle response pulse.
//
// state  | meaning
// IDLE   | waiting for a request; ready driven combinationally from the grant
// ACCESS | registered mem_* strobes active; store commits / load captured at closing edge
// RESP   | response pulse on the latched port
module dmem_arbiter #(
  parameter int MEM_BYTES  = 1024,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [2:0]  req0_funct3,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [2:0]  req1_funct3,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, port_q, err_q;
  logic        grant0, grant1, accept;
  logic        sel_we, sel_err, f3_ok, misaligned;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_f3, size_m1;
  logic [32:0] last_byte;

  // Ties go to the port that did not win last; FIXED_PRIO pins ties to port 0.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | FIXED_PRIO | last_grant_q);
    grant1 = req1_valid & ~grant0;
    accept = (state_q == IDLE) & (grant0 | grant1);
  end

  assign req0_ready = rst_n & (state_q == IDLE) & grant0;
  assign req1_ready = rst_n & (state_q == IDLE) & grant1;

  always_comb begin
    sel_we    = grant1 ? req1_we     : req0_we;
    sel_addr  = grant1 ? req1_addr   : req0_addr;
    sel_wdata = grant1 ? req1_wdata  : req0_wdata;
    sel_f3    = grant1 ? req1_funct3 : req0_funct3;
    case (sel_f3[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase
    if (sel_we) f3_ok = sel_f3 inside {3'b000, 3'b001, 3'b010};
    else        f3_ok = sel_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = ((sel_f3[1:0] == 2'b01) & sel_addr[0]) |
                 ((sel_f3[1:0] == 2'b10) & (sel_addr[1:0] != 2'b00));
    // 33-bit sum so an access near 0xFFFF_FFFF cannot wrap back into range.
    last_byte = {1'b0, sel_addr} + {30'b0, size_m1};
    sel_err   = ~f3_ok | misaligned | (last_byte >= 33'(MEM_BYTES));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // mem_* are loaded on accept and cleared on the next edge, so they are high only in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q   <= 1'b1;
      port_q         <= 1'b0;
      err_q          <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_funct3     <= '0;
      rsp0_valid     <= 1'b0;
      rsp0_rdata     <= '0;
      rsp0_err       <= 1'b0;
      rsp1_valid     <= 1'b0;
      rsp1_rdata     <= '0;
      rsp1_err       <= 1'b0;
    end else begin
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_funct3     <= '0;
      rsp0_valid     <= 1'b0;
      rsp0_rdata     <= '0;
      rsp0_err       <= 1'b0;
      rsp1_valid     <= 1'b0;
      rsp1_rdata     <= '0;
      rsp1_err       <= 1'b0;
      if (accept) begin
        port_q         <= grant1;
        err_q          <= sel_err;
        last_grant_q   <= grant1;
        mem_address    <= sel_addr;
        mem_write_data <= sel_wdata;
        mem_funct3     <= sel_f3;
        mem_write      <= sel_we & ~sel_err;
        mem_read       <= ~sel_we & ~sel_err;
      end
      if (state_q == ACCESS) begin
        rsp0_valid <= ~port_q;
        rsp1_valid <= port_q;
        rsp0_err   <= ~port_q & err_q;
        rsp1_err   <= port_q & err_q;
        rsp0_rdata <= (mem_read & ~port_q) ? mem_read_data : 32'h0;
        rsp1_rdata <= (mem_read & port_q)  ? mem_read_data : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural byte memory, scoreboard of expected responses,
// a second instance with FIXED_PRIO=1 for the priority check.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic [2:0]  req0_funct3 = 0, req1_funct3 = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [2:0]  mem_funct3;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_rsp0_err, fp_rsp1_err;
  logic [31:0] fp_rsp0_rdata, fp_rsp1_rdata, fp_mem_address, fp_mem_write_data;
  logic        fp_mem_read, fp_mem_write;
  logic [2:0]  fp_mem_funct3;

  dmem_arbiter #(.MEM_BYTES(1024), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_funct3(req0_funct3),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_funct3(req1_funct3),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data));

  dmem_arbiter #(.MEM_BYTES(1024), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_funct3(req0_funct3),
    .rsp0_valid(fp_rsp0_valid), .rsp0_rdata(fp_rsp0_rdata), .rsp0_err(fp_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_funct3(req1_funct3),
    .rsp1_valid(fp_rsp1_valid), .rsp1_rdata(fp_rsp1_rdata), .rsp1_err(fp_rsp1_err),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_address(fp_mem_address),
    .mem_write_data(fp_mem_write_data), .mem_funct3(fp_mem_funct3), .mem_read_data(32'h0));

  // Behavioural little-endian memory: synchronous write, combinational read with extension.
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    mem_read_data = '0;
    ma = mem_address[9:0];
    b0 = mem[ma];
    b1 = mem[ma + 10'd1];
    b2 = mem[ma + 10'd2];
    b3 = mem[ma + 10'd3];
    case (mem_funct3)
      3'b000:  mem_read_data = {{24{b0[7]}}, b0};
      3'b001:  mem_read_data = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_read_data = {b3, b2, b1, b0};
      3'b100:  mem_read_data = {24'h0, b0};
      3'b101:  mem_read_data = {16'h0, b1, b0};
      default: mem_read_data = '0;
    endcase
  end

  int cyc = 0, wr_cnt = 0, strobe_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      case (mem_funct3[1:0])
        2'b00: mem[mem_address[9:0]] <= mem_write_data[7:0];
        2'b01: begin
          mem[mem_address[9:0]]         <= mem_write_data[7:0];
          mem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
        end
        default: begin
          mem[mem_address[9:0]]         <= mem_write_data[7:0];
          mem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
          mem[mem_address[9:0] + 10'd2] <= mem_write_data[23:16];
          mem[mem_address[9:0] + 10'd3] <= mem_write_data[31:24];
        end
      endcase
    end
    if (mem_read | mem_write) strobe_cnt <= strobe_cnt + 1;
  end

  int tests = 0, fails = 0;

  typedef struct {int port; logic [31:0] rdata; logic err; int cyc;} exp_t;
  exp_t sb[$];

  typedef struct {int port; logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] f3;
                  logic [31:0] rd; logic err;} req_t;

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Drives one request, waits (bounded) for acceptance and pushes the expected response.
  task automatic do_req(input req_t r);
    bit ok = 0;
    if (r.port == 0) begin
      req0_we = r.we; req0_addr = r.addr; req0_wdata = r.wdata; req0_funct3 = r.f3; req0_valid = 1;
    end else begin
      req1_we = r.we; req1_addr = r.addr; req1_wdata = r.wdata; req1_funct3 = r.f3; req1_valid = 1;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((r.port == 0 && req0_ready) || (r.port == 1 && req1_ready)) begin ok = 1; break; end
    end
    if (ok) sb.push_back('{r.port, r.rd, r.err, cyc + 2});
    else begin
      tests++; fails++;
      $display("FAIL accept_timeout: port %0d addr %h never accepted within 20 cycles", r.port, r.addr);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic get_rsp(output int p, output logic [31:0] rd, output logic er, output int c);
    p = -1; rd = 'x; er = 'x; c = -1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp0_valid | rsp1_valid) begin
        p  = (rsp0_valid & rsp1_valid) ? 2 : (rsp1_valid ? 1 : 0);
        rd = rsp1_valid ? rsp1_rdata : rsp0_rdata;
        er = rsp1_valid ? rsp1_err : rsp0_err;
        c  = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    req0_we = 0; req0_addr = 32'h10; req0_funct3 = 3'b010; req0_valid = 1; req1_valid = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
    end
    tests++;
    if ({mem_read, mem_write, mem_address, mem_write_data, mem_funct3, rsp0_valid, rsp1_valid,
         rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err} !== '0) begin
      fails++; $display("FAIL reset_outputs: mem_rd %b mem_wr %b addr %h rsp_v %b%b, want all 0",
                        mem_read, mem_write, mem_address, rsp0_valid, rsp1_valid);
    end
    req1_valid = 0;
    rst_n = 1;
    #1;
    tests++;
    if (req0_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b, want 1", req0_ready); end
    #1 req0_valid = 0;
    begin
      int seen = 0;
      int s0 = strobe_cnt;
      repeat (4) @(negedge clk) if (rsp0_valid | rsp1_valid) seen++;
      tests++;
      if (seen != 0 || strobe_cnt != s0) begin
        fails++; $display("FAIL dropped_valid: got %0d rsp %0d strobes, want 0 0", seen, strobe_cnt - s0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    req_t t[2] = '{'{0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0},
                   '{0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0}};
    int p, c; logic [31:0] rd; logic er; exp_t e;
    for (int i = 0; i < 2; i++) begin
      do_req(t[i]);
      if (i == 0) begin
        tests++;
        if ({mem_write, mem_read, mem_address, mem_write_data, mem_funct3} !==
            {1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b010}) begin
          fails++; $display("FAIL store_strobe: wr %b rd %b addr %h data %h f3 %b, want 1 0 10 deadbeef 010",
                            mem_write, mem_read, mem_address, mem_write_data, mem_funct3);
        end
      end
      get_rsp(p, rd, er, c);
      if (sb.size() == 0) continue;
      e = sb.pop_front();
      tests++;
      if (p !== e.port || rd !== e.rdata || er !== e.err || c !== e.cyc) begin
        fails++; $display("FAIL store_load[%0d]: got port %0d rdata %h err %b cyc %0d, want port %0d rdata %h err %b cyc %0d",
                          i, p, rd, er, c, e.port, e.rdata, e.err, e.cyc);
      end
    end
  endtask

  // Both ports stream four loads each; grant order is observed on the chosen instance's ready.
  task automatic test_dual(input bit fp);
    int left0 = 4, left1 = 4, n = 0, g;
    int exp_q[$];
    for (int i = 0; i < 8; i++) exp_q.push_back(fp ? (i < 4 ? 0 : 1) : i % 2);
    apply_reset();
    req0_we = 0; req0_addr = 32'h10; req0_funct3 = 3'b010;
    req1_we = 0; req1_addr = 32'h10; req1_funct3 = 3'b010;
    req0_valid = 1; req1_valid = 1;
    while ((left0 > 0 || left1 > 0) && n < 100) begin
      logic g0, g1;
      @(negedge clk);
      g0 = fp ? fp_req0_ready : req0_ready;
      g1 = fp ? fp_req1_ready : req1_ready;
      if (g0 | g1) begin
        g = g1 ? 1 : 0;
        tests++;
        if ((g0 & g1) || exp_q.size() == 0 || g != exp_q[0]) begin
          fails++; $display("FAIL grant_order(fp=%0d): got ready %b%b, want port %0d", fp, g1, g0,
                            exp_q.size() ? exp_q[0] : -1);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (g0) left0--;
        if (g1) left1--;
      end
      @(posedge clk); #1;
      req0_valid = (left0 > 0); req1_valid = (left1 > 0);
      n++;
    end
    req0_valid = 0; req1_valid = 0;
    if (n >= 100) begin tests++; fails++; $display("FAIL grant_timeout(fp=%0d): %0d %0d left", fp, left0, left1); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_misaligned();
    req_t t[3] = '{'{1, 1'b1, 32'h11, 32'h0000AAAA, 3'b001, 32'h0, 1'b1},
                   '{1, 1'b1, 32'h12, 32'h55555555, 3'b010, 32'h0, 1'b1},
                   '{1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0}};
    int p, c, w0 = wr_cnt; logic [31:0] rd; logic er; exp_t e;
    for (int i = 0; i < 3; i++) begin
      do_req(t[i]);
      get_rsp(p, rd, er, c);
      if (sb.size() == 0) continue;
      e = sb.pop_front();
      tests++;
      if (p !== e.port || rd !== e.rdata || er !== e.err || c !== e.cyc) begin
        fails++; $display("FAIL misaligned[%0d]: got port %0d rdata %h err %b cyc %0d, want port %0d rdata %h err %b cyc %0d",
                          i, p, rd, er, c, e.port, e.rdata, e.err, e.cyc);
      end
    end
    tests++;
    if (wr_cnt != w0) begin fails++; $display("FAIL misaligned_nowrite: got %0d writes, want 0", wr_cnt - w0); end
  endtask

  task automatic test_range();
    req_t t[6] = '{'{0, 1'b0, 32'h3FE, 32'h0, 3'b010, 32'h0, 1'b1},
                   '{0, 1'b1, 32'h400, 32'h11, 3'b000, 32'h0, 1'b1},
                   '{0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1},
                   '{0, 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1},
                   '{0, 1'b0, 32'h3FC, 32'h0, 3'b010, 32'h0, 1'b0},
                   '{0, 1'b0, 32'h3FE, 32'h0, 3'b101, 32'h0, 1'b0}};
    int p, c, s0 = strobe_cnt; logic [31:0] rd; logic er; exp_t e;
    for (int i = 0; i < 6; i++) begin
      do_req(t[i]);
      get_rsp(p, rd, er, c);
      if (sb.size() == 0) continue;
      e = sb.pop_front();
      tests++;
      if (p !== e.port || rd !== e.rdata || er !== e.err || c !== e.cyc) begin
        fails++; $display("FAIL range[%0d]: got port %0d rdata %h err %b cyc %0d, want port %0d rdata %h err %b cyc %0d",
                          i, p, rd, er, c, e.port, e.rdata, e.err, e.cyc);
      end
    end
    tests++;
    if (strobe_cnt - s0 != 2) begin fails++; $display("FAIL range_strobes: got %0d, want 2", strobe_cnt - s0); end
  endtask

  task automatic test_sign_ext();
    req_t t[5] = '{'{0, 1'b1, 32'h10, 32'h80000000, 3'b010, 32'h0, 1'b0},
                   '{0, 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0},
                   '{1, 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0},
                   '{0, 1'b0, 32'h12, 32'h0, 3'b101, 32'h00008000, 1'b0},
                   '{1, 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8000, 1'b0}};
    int p, c; logic [31:0] rd; logic er; exp_t e;
    for (int i = 0; i < 5; i++) begin
      do_req(t[i]);
      get_rsp(p, rd, er, c);
      if (sb.size() == 0) continue;
      e = sb.pop_front();
      tests++;
      if (p !== e.port || rd !== e.rdata || er !== e.err || c !== e.cyc) begin
        fails++; $display("FAIL sign_ext[%0d]: got port %0d rdata %h err %b cyc %0d, want port %0d rdata %h err %b cyc %0d",
                          i, p, rd, er, c, e.port, e.rdata, e.err, e.cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p, c, seen = 0, w0 = wr_cnt; logic [31:0] rd; logic er; exp_t e; bit ok = 0;
    req0_we = 1; req0_addr = 32'h20; req0_wdata = 32'h12345678; req0_funct3 = 3'b010; req0_valid = 1;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (req0_ready) begin ok = 1; break; end end
    @(posedge clk); #1 req0_valid = 0;
    tests++;
    if (!ok || mem_write !== 1'b1) begin fails++; $display("FAIL midreset_setup: accepted %0d mem_write %b, want 1 1", ok, mem_write); end
    #2 rst_n = 0;
    #1;
    tests++;
    if ({mem_read, mem_write, mem_address, mem_write_data, mem_funct3, rsp0_valid, rsp1_valid,
         rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err, req0_ready, req1_ready} !== '0) begin
      fails++; $display("FAIL midreset_outputs: mem_wr %b addr %h rsp_v %b%b, want all 0",
                        mem_write, mem_address, rsp0_valid, rsp1_valid);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (5) @(negedge clk) if (rsp0_valid | rsp1_valid) seen++;
    tests++;
    if (seen != 0 || wr_cnt != w0) begin
      fails++; $display("FAIL midreset_dropped: got %0d rsp %0d writes, want 0 0", seen, wr_cnt - w0);
    end
    @(posedge clk); #1;
    do_req('{0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0});
    get_rsp(p, rd, er, c);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      tests++;
      if (p !== e.port || rd !== e.rdata || er !== e.err || c !== e.cyc) begin
        fails++; $display("FAIL midreset_next: got port %0d rdata %h err %b cyc %0d, want port %0d rdata %h err %b cyc %0d",
                          p, rd, er, c, e.port, e.rdata, e.err, e.cyc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_store_load();
    test_dual(1'b0);
    test_dual(1'b1);
    test_misaligned();
    test_range();
    test_sign_ext();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
